// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA 640x480@60 timing constants, sync bundle type and helpers.
package vga_timing_gen_pkg;

  localparam int unsigned CNT_W = 10;

  // Horizontal timing in pixel ticks
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  // Vertical timing in lines
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Sync/blank bundle carried through the delay line
  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic vid;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, vid: 1'b0};

  // Inclusive range test on a counter value
  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle from the VGA timing generator to renderers and the DAC stage.
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;

  logic             pix_ce;
  logic [CNT_W-1:0] x_pos;
  logic [CNT_W-1:0] y_pos;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic             frame_start;

  modport master (
    output pix_ce, x_pos, y_pos, hsync, vsync, video_on, frame_start
  );

  modport slave (
    input pix_ce, x_pos, y_pos, hsync, vsync, video_on, frame_start
  );
endinterface

// File: rtl/vga_sync_delay.sv
// Pixel-tick shift register aligning sync/blank with the glyph pipeline.
// DEPTH=0 still keeps one register so the outputs are never combinational.
module vga_sync_delay
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  pix_ce_i,
  input  sync_t d_i,
  output sync_t q_o
);

  localparam int unsigned STAGES = (DEPTH == 0) ? 1 : DEPTH;

  sync_t [STAGES-1:0] pipe_q;
  sync_t [STAGES-1:0] pipe_d;

  // Shift one stage per pixel tick
  always_comb begin
    pipe_d = pipe_q;
    if (pix_ce_i) begin
      pipe_d[0] = d_i;
      for (int i = 1; i < STAGES; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  // Stage registers; reset loads the inactive pattern everywhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= {STAGES{SYNC_IDLE}};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign q_o = pipe_q[STAGES-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-clock divider, x/y raster counters, raw
// sync/blank decode and a delayed sync/blank output via vga_sync_delay.
// Timing defaults come from the package; they are parameters only so a
// reduced raster can be exercised.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned PIPE_DLY = 2,
  parameter int unsigned H_VIS    = H_VISIBLE,
  parameter int unsigned H_FP     = H_FRONT,
  parameter int unsigned H_SW     = H_SYNC,
  parameter int unsigned H_BP     = H_BACK,
  parameter int unsigned V_VIS    = V_VISIBLE,
  parameter int unsigned V_FP     = V_FRONT,
  parameter int unsigned V_SW     = V_SYNC,
  parameter int unsigned V_BP     = V_BACK
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_VIS + H_FP + H_SW + H_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS_END    = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] H_SYNC_FIRST = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_LAST  = CNT_W'(H_VIS + H_FP + H_SW - 1);

  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_VIS + V_FP + V_SW + V_BP - 1);
  localparam logic [CNT_W-1:0] V_VIS_END    = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] V_SYNC_FIRST = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(V_VIS + V_FP + V_SW - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_ce_q, pix_ce_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             frame_q, frame_d;
  sync_t            raw_c;
  sync_t            dly;

  // Divider, raster counters and frame-start decode
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    pix_ce_d = (div_q == DIV_LAST);
    x_d      = x_q;
    y_d      = y_q;
    if (pix_ce_q) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
    // Flag the tick whose end wraps the raster to (0,0)
    frame_d = pix_ce_d && (x_d == H_LAST) && (y_d == V_LAST);
  end

  // Counter and strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      pix_ce_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      frame_q  <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_ce_q <= pix_ce_d;
      x_q      <= x_d;
      y_q      <= y_d;
      frame_q  <= frame_d;
    end
  end

  // Undelayed sync/blank decode from the counters
  always_comb begin
    raw_c         = SYNC_IDLE;
    raw_c.hsync_n = ~in_range(x_q, H_SYNC_FIRST, H_SYNC_LAST);
    raw_c.vsync_n = ~in_range(y_q, V_SYNC_FIRST, V_SYNC_LAST);
    raw_c.vid     = (x_q < H_VIS_END) && (y_q < V_VIS_END);
  end

  vga_sync_delay #(
    .DEPTH (PIPE_DLY)
  ) u_sync_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_ce_i (pix_ce_q),
    .d_i      (raw_c),
    .q_o      (dly)
  );

  assign vga.pix_ce      = pix_ce_q;
  assign vga.x_pos       = x_q;
  assign vga.y_pos       = y_q;
  assign vga.hsync       = dly.hsync_n;
  assign vga.vsync       = dly.vsync_n;
  assign vga.video_on    = dly.vid;
  assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default timing (div 4, delay 2), fast pixel (div 1,
// delay 0) and a reduced 16x13 raster (div 2, delay 3) for frame checks.
module tb_vga_timing_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();

  vga_timing_gen #(.CLK_DIV(4), .PIPE_DLY(2)) u_a (
    .clk(clk), .rst_n(rst_n), .vga(if_a)
  );

  vga_timing_gen #(.CLK_DIV(1), .PIPE_DLY(0)) u_b (
    .clk(clk), .rst_n(rst_n), .vga(if_b)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .PIPE_DLY(3),
    .H_VIS(8), .H_FP(2), .H_SW(3), .H_BP(3),
    .V_VIS(6), .V_FP(2), .V_SW(2), .V_BP(3)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .vga(if_c)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int a_first656, a_first_hlow, a_hlow, a_vid, a_fs, a_vlow, a_range_bad, a_idle_bad;
  int b_first656, b_first_hlow, b_hlow, b_vid, b_fs, b_pix_low, b_range_bad;
  int c_fs, c_first_fs, c_prev_fs, c_gap, c_vlow, c_vid, c_range_bad;
  int found;

  initial begin
    // ---- asynchronous reset entry, no clock edge involved
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_a_x", if_a.x_pos, 0);
    check("rst_a_y", if_a.y_pos, 0);
    check("rst_a_pix_ce", if_a.pix_ce, 0);
    check("rst_a_frame_start", if_a.frame_start, 0);
    check("rst_a_hsync", if_a.hsync, 1);
    check("rst_a_vsync", if_a.vsync, 1);
    check("rst_a_video_on", if_a.video_on, 0);
    check("rst_b_pix_ce", if_b.pix_ce, 0);
    step();
    step();
    rst_n = 1'b1;

    // ---- first 3200 clocks after release: startup and one full line
    a_first656 = -1; a_first_hlow = -1; a_hlow = 0; a_vid = 0; a_fs = 0;
    a_vlow = 0; a_range_bad = 0; a_idle_bad = 0;
    b_first656 = -1; b_first_hlow = -1; b_hlow = 0; b_vid = 0; b_fs = 0;
    b_pix_low = 0; b_range_bad = 0;
    for (int e = 1; e <= 3200; e++) begin
      step();
      if (e <= 3) check("a_pix_ce_before_clk4", if_a.pix_ce, 0);
      if (e == 4) begin
        check("a_pix_ce_clk4", if_a.pix_ce, 1);
        check("a_x_clk4", if_a.x_pos, 0);
      end
      if (e == 5) begin
        check("a_pix_ce_clk5", if_a.pix_ce, 0);
        check("a_x_clk5", if_a.x_pos, 1);
      end
      if (e <= 5 && (if_a.hsync !== 1'b1 || if_a.vsync !== 1'b1 || if_a.video_on !== 1'b0))
        a_idle_bad++;
      if (e == 2) check("b_x_clk2", if_b.x_pos, 1);
      if (if_b.pix_ce !== 1'b1) b_pix_low++;
      if (a_first656 < 0 && if_a.x_pos == 10'd656) a_first656 = e;
      if (a_first_hlow < 0 && if_a.hsync == 1'b0) a_first_hlow = e;
      if (if_a.hsync == 1'b0) a_hlow++;
      if (if_a.vsync == 1'b0) a_vlow++;
      if (if_a.video_on == 1'b1) a_vid++;
      if (if_a.frame_start == 1'b1) a_fs++;
      if (if_a.x_pos > 10'd799 || if_a.y_pos > 10'd524) a_range_bad++;
      if (b_first656 < 0 && if_b.x_pos == 10'd656) b_first656 = e;
      if (b_first_hlow < 0 && if_b.hsync == 1'b0) b_first_hlow = e;
      if (e <= 800 && if_b.hsync == 1'b0) b_hlow++;
      if (e <= 800 && if_b.video_on == 1'b1) b_vid++;
      if (if_b.frame_start == 1'b1) b_fs++;
      if (if_b.x_pos > 10'd799 || if_b.y_pos > 10'd524) b_range_bad++;
    end
    check("a_idle_outputs_clk1to5", a_idle_bad, 0);
    check("a_first_x656_clk", a_first656, 2625);
    check("a_hsync_delay_clks", a_first_hlow - a_first656, 8);
    check("a_hsync_low_clks", a_hlow, 384);
    check("a_video_on_clks_line", a_vid, 2560);
    check("a_vsync_low_line0", a_vlow, 0);
    check("a_frame_start_line", a_fs, 0);
    check("a_counter_range", a_range_bad, 0);
    check("b_pix_ce_always_high", b_pix_low, 0);
    check("b_first_x656_clk", b_first656, 657);
    check("b_hsync_delay_clks", b_first_hlow - b_first656, 1);
    check("b_hsync_low_clks", b_hlow, 96);
    check("b_video_on_clks_line", b_vid, 640);
    check("b_frame_start_lines", b_fs, 0);
    check("b_counter_range", b_range_bad, 0);

    // ---- reset in the middle of an hsync pulse on the default instance
    found = 0;
    for (int n = 0; n < 4000; n++) begin
      step();
      if (if_a.x_pos == 10'd700) begin
        found = 1;
        break;
      end
    end
    check("wait_a_x700", found, 1);
    check("a_hsync_mid_pulse", if_a.hsync, 0);
    check("a_y_mid_pulse", if_a.y_pos, 1);
    rst_n = 1'b0;
    #1;
    check("a_midrst_hsync", if_a.hsync, 1);
    check("a_midrst_vsync", if_a.vsync, 1);
    check("a_midrst_video_on", if_a.video_on, 0);
    check("a_midrst_x", if_a.x_pos, 0);
    check("a_midrst_y", if_a.y_pos, 0);
    check("a_midrst_pix_ce", if_a.pix_ce, 0);
    step();
    step();
    rst_n = 1'b1;

    // ---- reduced raster: three frames, frame pulses and vertical regions
    c_fs = 0; c_first_fs = -1; c_prev_fs = -1; c_gap = -1;
    c_vlow = 0; c_vid = 0; c_range_bad = 0;
    a_idle_bad = 0;
    for (int e = 1; e <= 1248; e++) begin
      step();
      if (e <= 5 && if_a.hsync !== 1'b1) a_idle_bad++;
      if (e == 5) check("a_restart_x_clk5", if_a.x_pos, 1);
      if (if_c.frame_start == 1'b1) begin
        c_fs++;
        if (c_first_fs < 0) c_first_fs = e;
        if (c_prev_fs >= 0) c_gap = e - c_prev_fs;
        c_prev_fs = e;
      end
      if (e <= 416 && if_c.vsync == 1'b0) c_vlow++;
      if (e <= 416 && if_c.video_on == 1'b1) c_vid++;
      if (if_c.x_pos > 10'd15 || if_c.y_pos > 10'd12) c_range_bad++;
    end
    check("a_restart_hsync_idle", a_idle_bad, 0);
    check("c_frame_start_count", c_fs, 3);
    check("c_first_frame_start_clk", c_first_fs, 416);
    check("c_frame_start_gap", c_gap, 416);
    check("c_vsync_low_clks", c_vlow, 64);
    check("c_video_on_clks", c_vid, 96);
    check("c_counter_range", c_range_bad, 0);

    // ---- reset inside both hsync and vsync regions of the reduced raster
    found = 0;
    for (int n = 0; n < 600; n++) begin
      step();
      if (if_c.x_pos == 10'd11 && if_c.y_pos == 10'd8) begin
        found = 1;
        break;
      end
    end
    check("wait_c_mid_sync", found, 1);
    check("c_vsync_mid_pulse", if_c.vsync, 0);
    rst_n = 1'b0;
    #1;
    check("c_midrst_hsync", if_c.hsync, 1);
    check("c_midrst_vsync", if_c.vsync, 1);
    check("c_midrst_video_on", if_c.video_on, 0);
    check("c_midrst_x", if_c.x_pos, 0);
    check("c_midrst_y", if_c.y_pos, 0);
    check("c_midrst_frame_start", if_c.frame_start, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    check("c_restart_x_clk3", if_c.x_pos, 1);
    check("c_restart_vsync", if_c.vsync, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pixel tick (100 MHz to 25 MHz); legal range 1..8.
REQ-002 Parameter PIPE_DLY, default 2: pixel ticks of delay applied to sync/blank outputs to match the downstream glyph-lookup pipeline; legal range 0..7.
REQ-003 clk  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 pix_ce  output  1  pixel-tick strobe, high for one clk in every CLK_DIV.
REQ-006 x_pos  output  10  horizontal counter, 0..799, undelayed; feeds text/tile renderers.
REQ-007 y_pos  output  10  vertical counter, 0..524, undelayed.
REQ-008 hsync  output  1  horizontal sync, active-low, delayed PIPE_DLY ticks.
REQ-009 vsync  output  1  vertical sync, active-low, delayed PIPE_DLY ticks.
REQ-010 video_on  output  1  visible-area flag, delayed PIPE_DLY ticks; downstream colour is forced black when low.
REQ-011 frame_start  output  1  one-clk pulse, coincident with the pix_ce on which (x_pos,y_pos) becomes (0,0).

Function
REQ-012 Divider counts 0..CLK_DIV-1 every clk and wraps; pix_ce is high when the count equals CLK_DIV-1; with CLK_DIV=1, pix_ce is constantly high after reset.
REQ-013 x_pos increments only on pix_ce; 799 -> 0 wrap.
REQ-014 y_pos increments only on a pix_ce where x_pos=799; at x_pos=799 and y_pos=524 both wrap to 0 on the same tick.
REQ-015 Horizontal regions (undelayed): visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-016 Vertical regions (undelayed): visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-017 Raw hsync_n = 0 iff 656<=x_pos<=751; raw vsync_n = 0 iff 490<=y_pos<=491; raw vid = (x_pos<640)&&(y_pos<480); raw signals are combinational from the counters.
REQ-018 hsync, vsync, and video_on are the raw signals passed through a PIPE_DLY-stage shift register that advances only on pix_ce; with PIPE_DLY=0 they are the raw signals, registered once on pix_ce.
REQ-019 Outputs are registered with no combinational path from a counter to hsync, vsync, or video_on when PIPE_DLY>=1.
REQ-020 frame_start is registered; it is high on exactly one clk per 800*525 pixel ticks.
REQ-021 Arithmetic is unsigned, 10-bit; counters never take values outside their ranges (REQ-006, REQ-007), including after reset.

Reset
REQ-022 With rst_n low, immediately and without waiting for clk: divider=0, x_pos=0, y_pos=0, pix_ce=0, frame_start=0, hsync=1, vsync=1, video_on=0, and every delay-line stage is loaded with its inactive value (1,1,0).
REQ-023 After rst_n deasserts, the first pix_ce occurs on the CLK_DIV-th rising clk edge; x_pos steps 0->1 on that tick; no frame_start is produced for the reset-entry frame.
REQ-024 Reset asserted mid-line or mid-sync forces outputs inactive at once; no partial sync pulse continues after reset.

Structure
REQ-025 Timing constants (H/V visible, front porch, sync, back porch, totals) belong in the shared VGA parameter include; the module shall contain no literal timing numbers.
REQ-026 The delay line is a sub-module vga_sync_delay (parameter DEPTH, 3-bit data, pix_ce enable, async active-low reset to the inactive pattern); the divider and counters stay in the top module.

Verification
REQ-027 Reset pulse, then 4 clk idle -> pix_ce first high on clk 4, x_pos=1 on the following clk, hsync=1, vsync=1, video_on=0 throughout.
REQ-028 Run one line, PIPE_DLY=2 -> hsync low for exactly 96 ticks, beginning 2 ticks after x_pos first reads 656.
REQ-029 Run two frames -> frame_start pulses exactly once per frame, 420000 ticks (1680000 clk) apart; vsync low for exactly 1600 ticks per frame.
REQ-030 Count video_on-high ticks over one frame -> exactly 307200.
REQ-031 Assert rst_n low at x_pos=700, y_pos=490 (mid-sync) -> hsync=1, vsync=1, and counters=0 before the next clk edge; clean restart follows.
REQ-032 CLK_DIV=1, PIPE_DLY=0 -> pix_ce constant high; hsync falls 1 clk after x_pos reads 656.
